// File: rtl/arena_dumper.sv
// ============================================================================
// Module   : arena_dumper
// Brief    : Walks every arena row and streams each cell as one token on a
//            valid/ready channel. This is a read-only arena engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arena_dumper #(
    parameter int ARENA_WIDTH  = 10,
    parameter int ARENA_HEIGHT = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   ready,
    output logic [7:0]             arena_row_select,
    input  logic [ARENA_WIDTH-1:0] arena_columns,
    output logic [ARENA_WIDTH-1:0] arena_columns_new,
    output logic                   arena_columns_write,
    output logic                   cell_valid,
    input  logic                   cell_ready,
    output logic                   cell_alive,
    output logic                   cell_eol,
    output logic                   cell_eof
);

    localparam int                 c_COL_W    = (ARENA_WIDTH > 1) ? $clog2(ARENA_WIDTH) : 1;
    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(ARENA_WIDTH - 1);
    localparam logic [7:0]         c_LAST_ROW = 8'(ARENA_HEIGHT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [7:0]             r_row;
    logic [c_COL_W-1:0]     r_col;
    logic [ARENA_WIDTH-1:0] r_row_buf;
    logic [ARENA_WIDTH-1:0] w_shifted;
    logic                   w_eol;
    logic                   w_eof;
    logic                   w_xfer;

    // A shift keeps the cell select legal even when ARENA_WIDTH is 1.
    assign w_shifted = r_row_buf >> r_col;
    assign w_eol     = (r_col == c_LAST_COL);
    assign w_eof     = w_eol && (r_row == c_LAST_ROW);
    assign w_xfer    = (r_state == c_SHIFT) && cell_ready;

    assign arena_columns_new   = '0;
    assign arena_columns_write = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_row     <= 8'd0;
            r_col     <= '0;
            r_row_buf <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_row <= 8'd0;
                    end
                end
                c_FETCH: begin
                    r_row_buf <= arena_columns;
                    r_col     <= '0;
                end
                c_SHIFT: begin
                    if (w_xfer) begin
                        if (!w_eol) begin
                            r_col <= r_col + c_COL_W'(1);
                        end else if (!w_eof) begin
                            r_row <= r_row + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_FETCH;
            c_FETCH: w_next_state = c_SHIFT;
            c_SHIFT: begin
                if (w_xfer && w_eol) begin
                    w_next_state = w_eof ? c_IDLE : c_FETCH;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        ready            = 1'b0;
        cell_valid       = 1'b0;
        cell_alive       = 1'b0;
        cell_eol         = 1'b0;
        cell_eof         = 1'b0;
        arena_row_select = r_row;
        case (r_state)
            c_IDLE: begin
                ready            = 1'b1;
                arena_row_select = 8'd0;
            end
            c_SHIFT: begin
                cell_valid = 1'b1;
                cell_alive = w_shifted[0];
                cell_eol   = w_eol;
                cell_eof   = w_eof;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_arena_dumper.sv
// ============================================================================
// Module   : tb_arena_dumper
// Brief    : Directed bench for arena_dumper: 10x10 diagonal arena plus a
//            1x1 instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arena_dumper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready;
    logic [7:0] sel;
    logic [9:0] cols;
    logic [9:0] cols_new;
    logic       cols_wr;
    logic       cell_valid;
    logic       cell_ready = 1'b1;
    logic       cell_alive;
    logic       cell_eol;
    logic       cell_eof;

    logic       start1 = 1'b0;
    logic       ready1;
    logic [7:0] sel1;
    logic [0:0] cols1;
    logic [0:0] cols_new1;
    logic       cols_wr1;
    logic       valid1;
    logic       cready1 = 1'b1;
    logic       alive1;
    logic       eol1;
    logic       eof1;

    logic [9:0] arena [0:9];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        cols = '0;
        if (sel < 8'd10) cols = arena[sel[3:0]];
    end
    assign cols1 = 1'b1;

    arena_dumper #(.ARENA_WIDTH(10), .ARENA_HEIGHT(10)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .arena_row_select(sel), .arena_columns(cols),
        .arena_columns_new(cols_new), .arena_columns_write(cols_wr),
        .cell_valid(cell_valid), .cell_ready(cell_ready),
        .cell_alive(cell_alive), .cell_eol(cell_eol), .cell_eof(cell_eof)
    );

    arena_dumper #(.ARENA_WIDTH(1), .ARENA_HEIGHT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .ready(ready1),
        .arena_row_select(sel1), .arena_columns(cols1),
        .arena_columns_new(cols_new1), .arena_columns_write(cols_wr1),
        .cell_valid(valid1), .cell_ready(cready1),
        .cell_alive(alive1), .cell_eol(eol1), .cell_eof(eof1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_valid"}, cell_valid, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_wr"}, cols_wr, 0);
        chk({tag, "_new"}, cols_new, 0);
    endtask

    // One dump of the 10x10 arena. rnd adds random stalls, start_at re-pulses
    // start at that cell index, rst_at aborts with reset at that cell index.
    task automatic dump(input bit rnd, input int start_at, input int rst_at);
        int  k   = 0;
        int  cyc = 0;
        bit  done = 0;
        bit  aborted = 0;
        int  r, c;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("fetch0_ready", ready, 0);
        chk("fetch0_valid", cell_valid, 0);
        chk("fetch0_sel", sel, 0);
        while (!done && cyc < 2000) begin
            tick;
            cyc++;
            start = 1'b0;
            r = k / 10;
            c = k % 10;
            if (ready) begin
                done = 1;
            end else if (cell_valid) begin
                chk("cell_alive", cell_alive, (r == c) ? 1 : 0);
                chk("cell_eol", cell_eol, (c == 9) ? 1 : 0);
                chk("cell_eof", cell_eof, (k == 99) ? 1 : 0);
                chk("cell_sel", sel, r);
                chk("cell_wr", cols_wr, 0);
                if (k == rst_at) begin
                    #2 rst = 1'b1;
                    #1;
                    chk("arst_valid", cell_valid, 0);
                    chk("arst_ready", ready, 1);
                    chk("arst_sel", sel, 0);
                    tick;
                    rst = 1'b0;
                    tick;
                    check_idle("post_rst");
                    aborted = 1;
                    break;
                end
                if (k == start_at) start = 1'b1;
                cell_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (cell_ready) k++;
            end else begin
                chk("fetch_sel", sel, r);
                chk("fetch_col_start", c, 0);
            end
        end
        cell_ready = 1'b1;
        if (!aborted) begin
            chk("dump_done_in_budget", done, 1);
            chk("dump_transfers", k, 100);
            if (!rnd) chk("dump_cycles", cyc, 110);
            tick;
            check_idle("after_dump");
            tick;
            check_idle("after_dump2");
        end
    endtask

    initial begin
        for (int i = 0; i < 10; i++) arena[i] = 10'h001 << i;

        // Reset held: outputs already at reset values before any edge.
        #3;
        check_idle("in_reset");
        chk("in_reset_ready1", ready1, 1);
        chk("in_reset_valid1", valid1, 0);
        tick;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check_idle("idle_hold");
        end

        dump(1'b0, -1, -1);
        dump(1'b1, -1, -1);
        dump(1'b0, 33, -1);
        for (int i = 0; i < 3; i++) begin
            tick;
            check_idle("no_second_dump");
        end
        dump(1'b0, -1, 54);
        dump(1'b0, -1, -1);

        // 1x1 arena: a single cell that is both eol and eof.
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        chk("w1_fetch_ready", ready1, 0);
        chk("w1_fetch_valid", valid1, 0);
        tick;
        chk("w1_valid", valid1, 1);
        chk("w1_alive", alive1, 1);
        chk("w1_eol", eol1, 1);
        chk("w1_eof", eof1, 1);
        chk("w1_wr", cols_wr1, 0);
        tick;
        chk("w1_ready_back", ready1, 1);
        chk("w1_valid_low", valid1, 0);
        chk("w1_sel", sel1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
